// File: rtl/data_mem_access.sv
// data_mem_access: load/store unit between the datapath and the data bus.
// Runs one req/ack bus transaction per memory instruction and stalls the core.
module data_mem_access #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AccessErr,
    output logic        BusErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    a_q, a_d;
    logic [2:0]    f3_q, f3_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          acc_err_q, acc_err_d;
    logic          bus_err_q, bus_err_d;

    logic          req;
    logic          legal_f3;
    logic          misal;
    logic [3:0]    be_n;
    logic [31:0]   wd_n;
    logic [31:0]   ld_sh;
    logic [31:0]   ld_ext;
    logic [CW-1:0] cnt_inc;

    // Decode the incoming request: legality, alignment, lanes and store data
    always_comb begin
        req = MemRead | MemWrite;
        if (MemWrite) begin
            legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                       (funct3 == 3'b010);
        end else begin
            legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                       (funct3 == 3'b010) || (funct3 == 3'b100) ||
                       (funct3 == 3'b101);
        end
        misal = ((funct3[1:0] == 2'b01) && ALUResult[0]) ||
                ((funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00: begin
                be_n = 4'b0001 << ALUResult[1:0];
                wd_n = {4{WriteData[7:0]}};
            end
            2'b01: begin
                be_n = 4'b0011 << {ALUResult[1], 1'b0};
                wd_n = {2{WriteData[15:0]}};
            end
            default: begin
                be_n = 4'b1111;
                wd_n = WriteData;
            end
        endcase
    end

    // Align the returned word to the accessed lane and extend it
    always_comb begin
        ld_sh = bus_rdata >> {a_q, 3'b000};
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'b100:  ld_ext = {24'd0, ld_sh[7:0]};
            3'b101:  ld_ext = {16'd0, ld_sh[15:0]};
            default: ld_ext = ld_sh;
        endcase
    end

    // Stall covers the request cycle in IDLE and every BUS cycle
    always_comb begin
        case (state_q)
            S_IDLE:  Stall = req;
            S_BUS:   Stall = 1'b1;
            default: Stall = 1'b0;
        endcase
    end

    // Transaction sequencing; error flags are cleared unless set this cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        f3_d      = f3_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        acc_err_d = 1'b0;
        bus_err_d = 1'b0;
        cnt_inc   = cnt_q + CW'(1);
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    a_d  = ALUResult[1:0];
                    f3_d = funct3;
                    if (legal_f3 && !misal) begin
                        state_d = S_BUS;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = MemWrite;
                        addr_d  = {ALUResult[31:2], 2'b00};
                        be_d    = be_n;
                        wdata_d = wd_n;
                    end else begin
                        state_d   = S_DONE;
                        acc_err_d = 1'b1;
                        rdata_d   = '0;
                    end
                end
            end
            S_BUS: begin
                if (bus_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = ld_ext;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == MAX_CNT) begin
                        state_d   = S_DONE;
                        req_d     = 1'b0;
                        bus_err_d = 1'b1;
                        rdata_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            f3_q      <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            acc_err_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            f3_q      <= f3_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            acc_err_q <= acc_err_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign ReadData  = rdata_q;
    assign AccessErr = acc_err_q;
    assign BusErr    = bus_err_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_access.sv
// tb_data_mem_access: directed and random load/store transactions
// checked against a byte-level behavioural model of the unit.
module tb_data_mem_access;

    localparam int MW = 16;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        AccessErr;
    logic        BusErr;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_cmp;
    int n_bad;
    logic [31:0] model_rd;

    data_mem_access #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall), .AccessErr(AccessErr),
        .BusErr(BusErr), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_legal(input bit st, input logic [2:0] f3);
        if (st) return (f3 <= 3'd2);
        return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3,
                                             input int a,
                                             input logic [31:0] rd);
        int bs[4];
        int sz;
        int v;
        for (int i = 0; i < 4; i++) bs[i] = int'((rd >> (8 * i)) & 32'hFF);
        sz = acc_size(f3);
        if (sz == 4) return rd;
        v = bs[a];
        if (sz == 2) v = v + 256 * bs[a + 1];
        if (f3[2] == 1'b0) begin
            if (sz == 1 && v >= 128) v = v - 256;
            if (sz == 2 && v >= 32768) v = v - 65536;
        end
        return 32'(v);
    endfunction

    // One memory instruction from IDLE back to IDLE; dly < 0 means no ack.
    task automatic run_op(input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int dly, input logic [31:0] rd);
        int a;
        int sz;
        int nbus;
        bit err;
        bit tmo;
        logic [3:0] e_be;
        logic [31:0] e_wd;
        a = int'(addr[1:0]);
        sz = acc_size(f3);
        err = !is_legal(st, f3) || ((a % sz) != 0);
        e_be = '0;
        e_wd = '0;
        if (!err) for (int i = 0; i < sz; i++) e_be[a + i] = 1'b1;
        for (int i = 0; i < 4; i++) e_wd[8 * i +: 8] = wd[8 * (i % sz) +: 8];
        MemWrite = st;
        MemRead = !st;
        funct3 = f3;
        ALUResult = addr;
        WriteData = wd;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("idle_stall", 32'(Stall), 32'd1);
        chk("idle_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        tmo = 1'b0;
        if (err) begin
            MemRead = 1'b0;
            MemWrite = 1'b0;
            model_rd = '0;
            @(negedge clk);
            chk("err_accerr", 32'(AccessErr), 32'd1);
            chk("err_buserr", 32'(BusErr), 32'd0);
            chk("err_req", 32'(bus_req), 32'd0);
            chk("err_stall", 32'(Stall), 32'd0);
            chk("err_rdata", ReadData, model_rd);
        end else begin
            nbus = (dly >= 0 && dly < MW) ? dly + 1 : MW;
            tmo = !(dly >= 0 && dly < MW);
            for (int k = 0; k < nbus; k++) begin
                bus_ack = (k == dly);
                bus_rdata = (k == dly) ? rd : $urandom;
                @(negedge clk);
                chk("bus_req", 32'(bus_req), 32'd1);
                chk("bus_stall", 32'(Stall), 32'd1);
                chk("bus_we", 32'(bus_we), 32'(st));
                chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
                chk("bus_be", 32'(bus_be), 32'(e_be));
                if (st) chk("bus_wdata", bus_wdata, e_wd);
                @(posedge clk); #1;
            end
            MemRead = 1'b0;
            MemWrite = 1'b0;
            bus_ack = $urandom_range(0, 1) == 1;
            bus_rdata = $urandom;
            if (tmo) model_rd = '0;
            else if (!st) model_rd = load_val(f3, a, rd);
            @(negedge clk);
            chk("done_stall", 32'(Stall), 32'd0);
            chk("done_req", 32'(bus_req), 32'd0);
            chk("done_buserr", 32'(BusErr), 32'(tmo));
            chk("done_accerr", 32'(AccessErr), 32'd0);
            chk("done_rdata", ReadData, model_rd);
        end
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("idle_rdata", ReadData, model_rd);
        chk("idle_noerr", 32'({AccessErr, BusErr, bus_req}), 32'd0);
        chk("idle_nostall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req"}, 32'(bus_req), 32'd0);
        chk({tag, "_we"}, 32'(bus_we), 32'd0);
        chk({tag, "_addr"}, bus_addr, 32'd0);
        chk({tag, "_be"}, 32'(bus_be), 32'd0);
        chk({tag, "_wdata"}, bus_wdata, 32'd0);
        chk({tag, "_rdata"}, ReadData, 32'd0);
        chk({tag, "_errs"}, 32'({AccessErr, BusErr}), 32'd0);
    endtask

    initial begin
        bit st;
        int dly;
        logic [31:0] ad;
        n_cmp = 0;
        n_bad = 0;
        model_rd = '0;
        reset = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        funct3 = '0;
        ALUResult = '0;
        WriteData = '0;
        bus_ack = 1'b0;
        bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("rst");
        chk("rst_stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        run_op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 32'h80FF_1234);
        chk("lb_val", model_rd, 32'hFFFF_FF80);
        run_op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 3, 32'hBEEF_0000);
        chk("lhu_val", model_rd, 32'h0000_BEEF);
        run_op(1'b1, 3'b000, 32'h0000_0101, 32'h1234_56A5, 0, 32'h0);
        chk("sb_hold", model_rd, 32'h0000_BEEF);
        run_op(1'b0, 3'b010, 32'h0000_0006, 32'h0, 0, 32'h0);
        run_op(1'b0, 3'b011, 32'h0000_0000, 32'h0, 0, 32'h0);
        run_op(1'b0, 3'b010, 32'h0000_0040, 32'h0, 0, 32'hCAFE_F00D);
        run_op(1'b0, 3'b010, 32'h0000_0020, 32'h0, -1, 32'h0);
        run_op(1'b0, 3'b010, 32'h0000_0024, 32'h0, MW - 1, 32'h1357_9BDF);

        MemRead = 1'b1;
        funct3 = 3'b010;
        ALUResult = 32'h0000_0080;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstb_req", 32'(bus_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check_zero("rstb");
        chk("rstb_stall", 32'(Stall), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        MemRead = 1'b0;
        model_rd = '0;
        run_op(1'b1, 3'b010, 32'h0000_0010, 32'h0BAD_F00D, 1, 32'h0);

        for (int n = 0; n < 150; n++) begin
            st = $urandom_range(0, 1) == 1;
            ad = $urandom;
            dly = int'($urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) dly = -1;
            if ($urandom_range(0, 15) == 0) dly = MW + 2;
            run_op(st, 3'($urandom_range(0, 7)), ad, $urandom, dly,
                   $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_access.md
# data_mem_access

Load/store unit sitting directly downstream of the single-cycle datapath. It takes the datapath's memory address (`ALUResult`), store data (`WriteData`) and the control unit's load/store request. It runs a req/ack transaction on the data-memory bus and returns aligned, sign- or zero-extended load data to the datapath's `ReadData` input. While a transaction is outstanding it asserts `Stall` so the core holds PC and register-file writes.

## Interface
Parameters:
- `MAX_WAIT`, default 16: bus cycles without `bus_ack` before a transaction is aborted as a bus error; legal range ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `MemRead`  in  1  load request for the current instruction.
- `MemWrite`  in  1  store request for the current instruction; takes priority if both are high.
- `funct3`  in  3  access type: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- `ALUResult`  in  32  byte address.
- `WriteData`  in  32  store data, right-aligned.
- `ReadData`  out  32  extended load result, to the datapath result mux.
- `Stall`  out  1  core must hold state while high.
- `AccessErr`  out  1  one-cycle pulse: misaligned address or illegal `funct3`.
- `BusErr`  out  1  one-cycle pulse: `MAX_WAIT` expired.
- `bus_req`  out  1  transaction request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word address: `ALUResult` with bits [1:0] forced to 0.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_ack`  in  1  transaction complete; `bus_rdata` is valid in the same cycle.
- `bus_rdata`  in  32  read word.

## Operation
- **FSM states:** IDLE, BUS, DONE.
- **IDLE:**
  - `Stall` = `MemRead | MemWrite` (combinational).
  - On a request, latch the address, `funct3`, the direction, and the lane-aligned write data.
  - A legal, aligned access goes to BUS. A misaligned or illegal access goes to DONE with the error flagged and no bus activity.
- **Alignment rules:**
  - H accesses require `addr[0]` = 0.
  - W accesses require `addr[1:0]` = 0.
  - Illegal `funct3`: 011, 110, 111 for loads; anything other than 000/001/010 for stores.
- **Byte enables and store data:**
  - B: `bus_be` = 0001 << `addr[1:0]`; `bus_wdata` = `{4{WriteData[7:0]}}`.
  - H: `bus_be` = 0011 << (2·`addr[1]`); `bus_wdata` = `{2{WriteData[15:0]}}`.
  - W: `bus_be` = 1111; `bus_wdata` = `WriteData`.
  - Loads drive the same `bus_be` pattern.
- **BUS:**
  - `bus_req` = 1. All `bus_*` outputs are registered and held constant until ack.
  - A wait counter (width `$clog2(MAX_WAIT+1)`) is cleared on entry and increments each cycle without ack.
  - On `bus_ack`: for a load, register the extended data; then go to DONE.
  - If the counter reaches `MAX_WAIT` without ack: go to DONE with `BusErr`, and `ReadData` = 0.
- **Load extraction:**
  - Shift `bus_rdata` right by 8·`addr[1:0]`.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- **DONE:**
  - `Stall` = 0, so the core commits this cycle.
  - `ReadData` is valid.
  - `AccessErr` or `BusErr` pulses here if flagged.
  - Next state is IDLE unconditionally. A request seen in IDLE on the next cycle belongs to the next instruction.
- **Holding values:**
  - `ReadData` holds its last value outside DONE.
  - Stores leave `ReadData` unchanged; errors set it to 0.
- **Late ack:** a `bus_ack` in IDLE or DONE is ignored.
- **Reset values** (`reset` = 0 at an edge): state IDLE, counter 0. `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `ReadData`, `AccessErr`, `BusErr` are all 0. `Stall` follows IDLE rules.
- **Reset mid-transaction:** `bus_req` drops at that edge; no error pulses; an ack in the same cycle is discarded.

## Timing
- **Bus access, ack in the first BUS cycle:** IDLE (stall) → BUS (stall, ack) → DONE (commit). That is 3 cycles per memory instruction, 2 of them stalled.
- **Each extra wait cycle** adds 1 cycle. The worst case is 2 + `MAX_WAIT` cycles.
- **Erroneous access:** IDLE → DONE, 2 cycles, with `bus_req` never asserted.
- **Bus protocol:** `bus_req` goes high on the edge leaving IDLE and low on the edge after ack is sampled. At most one transaction is outstanding.
- **Status outputs:** `ReadData`, `AccessErr` and `BusErr` are registered, valid only in DONE, and change on the DONE-entry edge.

## Test plan
- **LB sign-extension:** LB at 0x1003, `bus_rdata` = 0x80FF_1234, immediate ack → `bus_addr` = 0x1000, `bus_be` = 1000; in DONE `ReadData` = 0xFFFF_FF80; `Stall` high for exactly 2 cycles.
- **LHU zero-extension:** LHU at 0x2002, `bus_rdata` = 0xBEEF_0000, ack after 3 wait cycles → `bus_be` = 1100, `ReadData` = 0x0000_BEEF, `Stall` high for 5 cycles, bus outputs stable throughout.
- **SB lane replication:** SB at 0x0101, `WriteData` = 0x1234_56A5 → `bus_we` = 1, `bus_be` = 0010, `bus_wdata` = 0xA5A5_A5A5, `ReadData` unchanged.
- **Misaligned word:** LW at 0x0006 → `bus_req` never 1, `AccessErr` pulse in cycle 2, `ReadData` = 0, and the same pulse for LW with `funct3` = 011.
- **Timeout:** `MAX_WAIT` = 16, no ack → `BusErr` pulses after 16 BUS cycles, `bus_req` drops, `ReadData` = 0, and an ack arriving in DONE is ignored.
- **Reset mid-BUS:** `reset` = 0 while in BUS with `MemRead` still high → next cycle `bus_req` = 0, all registered outputs 0, state IDLE; a following SW at 0x10 completes normally.
